ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host to the keyboard over the shared open-collector PS/2 clock/data lines, using the device-clocked host-to-device frame. It sits beside the keyboard receiver on the same two pads. Its outputs are pull-low enables that drive the tri-state pad logic.

---
 rtl/ps2_host_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx - PS/2 host-to-device command transmitter.
//
// Sends one byte to the keyboard using the device-clocked host-to-device
// frame: the host inhibits the bus, issues request-to-send by pulling data low,
// and then releases the clock. After that the device clocks out
// start/8 data (LSB first)/odd parity/stop. The host then samples the device ACK.
//
// Optional build macro: PS2_TX_TIMEOUT_EN enables a watchdog on the spacing
// of device clock falling edges. The watchdog is active during the transfer,
// ACK and wait-for-idle phases.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous reset, active-high
//   ps2_clk_in   PS/2 clock pad level (asynchronous)
//   ps2_data_in  PS/2 data pad level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   tx_data      command byte
//   tx_valid     send request, taken when tx_ready is high
//   tx_ready     high only while idle
//   done         one-cycle end-of-transfer pulse
//   err          valid with done: 1 = NACK or timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE
    } state_t;

    state_t           state, state_n;
    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             fall;
    logic [9:0]       shift, shift_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             nack, nack_n;
    logic             clk_oe_n, data_oe_n, done_n, err_n;

    // The oldest two synchronizer taps are used for edge detection.
    // This keeps the first, possibly metastable flop out of the decision.
    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            clk_sync    <= 3'b111;  // idle bus level, so reset causes no false fall
            data_sync   <= 2'b11;
            shift       <= '0;
            bit_cnt     <= '0;
            cnt         <= '0;
            nack        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            clk_sync    <= {clk_sync[1:0], ps2_clk_in};
            data_sync   <= {data_sync[0], ps2_data_in};
            shift       <= shift_n;
            bit_cnt     <= bit_cnt_n;
            cnt         <= cnt_n;
            nack        <= nack_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

    // Pad enables are computed here and registered above.
    // This keeps them glitch-free and aligned with the state they belong to.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        cnt_n     = cnt;
        nack_n    = nack;
        clk_oe_n  = 1'b0;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    shift_n  = {1'b1, ~^tx_data, tx_data};
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                cnt_n     = cnt + 1'b1;
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;       // start bit asserted under inhibit = RTS
                    state_n   = RTS;
                end
            end
            RTS: begin
                data_oe_n = 1'b1;
                bit_cnt_n = '0;
                cnt_n     = '0;
                state_n   = XFER;
            end
            XFER: begin
                // Data is updated right after a device fall.
                // The device samples it on the following rising edge.
                if (fall) begin
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b0, shift[9:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9)
                        state_n = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    nack_n  = data_sync[1];
                    state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                data_oe_n = 1'b0;
                if (clk_sync[1] && data_sync[1]) begin
                    done_n  = 1'b1;
                    err_n   = nack;
                    state_n = IDLE;
                end
            end
            default: begin
                data_oe_n = 1'b0;
                state_n   = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // The watchdog counts cycles since the last device fall.
        // It overrides the normal path when the device goes silent.
        if (state == XFER || state == ACK || state == WAIT_IDLE) begin
            if (fall) begin
                cnt_n = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                done_n    = 1'b1;
                err_n     = 1'b1;
                state_n   = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, done, err;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
        .clk(clk), .clr(clr),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic       err;
        bit         chk_frame;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    int         fall_cyc = 0;
    logic [9:0] dev_frame = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected transfer.
    always @(negedge clk) begin
        if (!clr && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_frame)
                    chk("wire_frame", {22'd0, dev_frame}, {22'd0, e.frame});
                chk("ready_at_done", {31'd0, tx_ready}, 32'd1);
                chk("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            end
        end
    end

    // Device model: checks the host inhibit/RTS phases and supplies nfalls clocks.
    // It samples the data line on each rising edge. On fall 11 it pulls data low if ack is set.
    task automatic device_run(input int nfalls, input bit ack);
        int n_inh = 0, n_rts = 0, guard = 0;
        dev_frame = '0;
        while (ps2_clk_oe !== 1'b1 && guard < 100) begin
            @(negedge clk); guard++;
        end
        while (ps2_clk_oe === 1'b1 && guard < 100000) begin
            if (ps2_data_oe === 1'b1) n_rts++; else n_inh++;
            @(negedge clk); guard++;
        end
        chk("inhibit_len", n_inh, INH);
        chk("rts_len", n_rts, 1);
        chk("start_bit", {31'd0, ps2_data_oe}, 32'd1);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) dev_frame[k-1] = ps2_data_in;
        end
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int start);
        int guard = 0;
        while (done_cnt == start && guard < 5000) begin
            @(negedge clk); guard++;
        end
        if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input bit ack);
        int start = done_cnt;
        exp_t e;
        e.frame = {1'b1, par, d};
        e.err = ~ack;
        e.chk_frame = 1'b1;
        sb.push_back(e);
        issue(d);
        device_run(11, ack);
        wait_done(start);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int start;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);

        // Reset in the middle of the frame after 4 device falls
        start = done_cnt;
        issue(8'h12);
        device_run(4, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        repeat (200) @(negedge clk);
        chk("midrst_no_done", done_cnt, start);

        // The expected parity values below are computed by hand (odd parity).
        send(8'hED, 1'b1, 1'b1);
        send(8'h00, 1'b1, 1'b1);
        send(8'h03, 1'b1, 1'b1);
        send(8'h02, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        send(8'hF4, 1'b0, 1'b0);   // NACK

        // A second request while busy must be dropped
        begin
            exp_t e;
            start = done_cnt;
            e.frame = {1'b1, 1'b1, 8'hAA};
            e.err = 1'b0;
            e.chk_frame = 1'b1;
            sb.push_back(e);
            issue(8'hAA);
            fork
                device_run(11, 1'b1);
                begin
                    repeat (5) @(negedge clk);
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            join
            wait_done(start);
            repeat (200) @(negedge clk);
            chk("busy_one_done", done_cnt, start + 1);
            chk("busy_no_second", {31'd0, ps2_clk_oe}, 32'd0);
        end

`ifdef PS2_TX_TIMEOUT_EN
        begin
            exp_t e;
            start = done_cnt;
            e.frame = '0;
            e.err = 1'b1;
            e.chk_frame = 1'b0;
            sb.push_back(e);
            issue(8'h5A);
            device_run(5, 1'b0);
            wait_done(start);
            // The pad fall is 3 cycles ahead of the detected fall because of the
            // synchronizer. The watchdog then fires TO cycles after the detected fall.
            chk("timeout_latency", done_cyc - fall_cyc, TO + 3);
        end
`endif

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
